// File: rtl/quan_pkg.sv
// Shared constants, mode encodings and loader FSM states for the quantization scale path.
package quan_pkg;

    localparam int SCALE_WORD_WIDTH = 512;
    localparam int SCALE_WIDTH      = 8;
    localparam int SCALE_SET_WIDTH  = 16;
    localparam int SCALE_REGS_NUM   = 64;

    localparam int SCALES_PER_WORD  = SCALE_WORD_WIDTH / SCALE_WIDTH;      // 64
    localparam int SETS_PER_WORD    = SCALE_WORD_WIDTH / SCALE_SET_WIDTH;  // 32
    localparam int WORD_BYTES       = SCALE_WORD_WIDTH / 8;

    localparam logic [3:0] MODE_SCALE8 = 4'd0;
    localparam logic [3:0] MODE_SET16  = 4'd1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CHECK,
        ST_REQ,
        ST_WAIT,
        ST_WRITE,
        ST_FIN
    } loader_state_t;

endpackage

// File: rtl/quan_scale_loader.sv
// Fetches 1-2 scale words per tile load and writes them to the scale register file.
// Latency start->done 5 cycles (one word) / 9 cycles (two words) with a zero-wait buffer; stalls on rd_req_ready / rd_data_valid.
module quan_scale_loader
    import quan_pkg::*;
#(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        load_start,
    input  logic [3:0]                  load_mode,
    input  logic [ADDR_WIDTH-1:0]       load_base_addr,
    input  logic [7:0]                  load_channel_num,
    output logic                        load_busy,
    output logic                        load_done,
    output logic                        cfg_err,
    output logic                        rd_req_valid,
    input  logic                        rd_req_ready,
    output logic [ADDR_WIDTH-1:0]       rd_req_addr,
    input  logic                        rd_data_valid,
    output logic                        rd_data_ready,
    input  logic [SCALE_WORD_WIDTH-1:0] rd_data,
    output logic                        scale_set,
    output logic [3:0]                  mode,
    output logic [SCALE_WORD_WIDTH-1:0] scale_word,
    output logic [7:0]                  scale_reg_start,
    output logic [7:0]                  scale_reg_size
);

    localparam logic [7:0]            SETS8  = 8'(SETS_PER_WORD);
    localparam logic [7:0]            REGS8  = 8'(SCALE_REGS_NUM);
    localparam logic [ADDR_WIDTH-1:0] STRIDE = ADDR_WIDTH'(WORD_BYTES);

    loader_state_t         state_q, state_d;
    logic [ADDR_WIDTH-1:0] base_q;
    logic [7:0]            num_q;
    logic                  word_idx_q;
    logic                  req_armed_q;

    logic       cmd_legal;
    logic       more_words;
    logic [7:0] remain;
    logic [7:0] next_start;
    logic [7:0] next_size;

    assign cmd_legal  = (mode <= MODE_SET16) && (num_q != 8'd0) && (num_q <= REGS8);
    assign more_words = (mode == MODE_SET16) && !word_idx_q && (num_q > SETS8);
    assign remain     = word_idx_q ? (num_q - SETS8) : num_q;
    assign next_start = word_idx_q ? (SETS8 + 8'd1) : 8'd1;
    assign next_size  = ((mode == MODE_SET16) && (remain > SETS8)) ? SETS8 : remain;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        load_busy     = (state_q != ST_IDLE);
        load_done     = 1'b0;
        cfg_err       = 1'b0;
        rd_req_valid  = 1'b0;
        rd_data_ready = 1'b0;
        scale_set     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (load_start) begin
                    state_d = ST_CHECK;
                end
            end
            ST_CHECK: begin
                cfg_err = !cmd_legal;
                state_d = cmd_legal ? ST_REQ : ST_IDLE;
            end
            ST_REQ: begin
                rd_req_valid = req_armed_q;
                if (req_armed_q && rd_req_ready) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                rd_data_ready = 1'b1;
                if (rd_data_valid) begin
                    state_d = ST_WRITE;
                end
            end
            ST_WRITE: begin
                scale_set = 1'b1;
                state_d   = more_words ? ST_REQ : ST_FIN;
            end
            ST_FIN: begin
                load_done = 1'b1;
                state_d   = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // A second request spends one cycle unarmed in REQ so the advanced address settles before valid rises.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode            <= '0;
            base_q          <= '0;
            num_q           <= '0;
            word_idx_q      <= 1'b0;
            req_armed_q     <= 1'b0;
            rd_req_addr     <= '0;
            scale_word      <= '0;
            scale_reg_start <= '0;
            scale_reg_size  <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (load_start) begin
                        mode   <= load_mode;
                        base_q <= load_base_addr;
                        num_q  <= load_channel_num;
                    end
                end
                ST_CHECK: begin
                    word_idx_q  <= 1'b0;
                    req_armed_q <= 1'b1;
                    rd_req_addr <= base_q;
                end
                ST_REQ: begin
                    if (!req_armed_q) begin
                        req_armed_q <= 1'b1;
                    end else if (rd_req_ready) begin
                        req_armed_q <= 1'b0;
                    end
                end
                ST_WAIT: begin
                    if (rd_data_valid) begin
                        scale_word      <= rd_data;
                        scale_reg_start <= next_start;
                        scale_reg_size  <= next_size;
                    end
                end
                ST_WRITE: begin
                    if (more_words) begin
                        word_idx_q  <= 1'b1;
                        rd_req_addr <= base_q + STRIDE;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_quan_scale_loader.sv
// Bench for quan_scale_loader: buffer responder with programmable stalls, event monitor and a per-load reference model.
`timescale 1ns/1ps
module tb_quan_scale_loader;
    import quan_pkg::*;

    localparam int AW = 32;
    localparam int WW = SCALE_WORD_WIDTH;

    logic          clk = 1'b0;
    logic          rst;
    logic          load_start;
    logic [3:0]    load_mode;
    logic [AW-1:0] load_base_addr;
    logic [7:0]    load_channel_num;
    logic          load_busy, load_done, cfg_err;
    logic          rd_req_valid, rd_req_ready;
    logic [AW-1:0] rd_req_addr;
    logic          rd_data_valid, rd_data_ready;
    logic [WW-1:0] rd_data;
    logic          scale_set;
    logic [3:0]    mode;
    logic [WW-1:0] scale_word;
    logic [7:0]    scale_reg_start, scale_reg_size;

    quan_scale_loader #(.ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst(rst),
        .load_start(load_start), .load_mode(load_mode),
        .load_base_addr(load_base_addr), .load_channel_num(load_channel_num),
        .load_busy(load_busy), .load_done(load_done), .cfg_err(cfg_err),
        .rd_req_valid(rd_req_valid), .rd_req_ready(rd_req_ready), .rd_req_addr(rd_req_addr),
        .rd_data_valid(rd_data_valid), .rd_data_ready(rd_data_ready), .rd_data(rd_data),
        .scale_set(scale_set), .mode(mode), .scale_word(scale_word),
        .scale_reg_start(scale_reg_start), .scale_reg_size(scale_reg_size)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]    start;
        logic [7:0]    size;
        logic [WW-1:0] word;
        logic [3:0]    md;
    } wr_rec_t;

    wr_rec_t       wr_q[$];
    logic [AW-1:0] rq_q[$];
    logic [WW-1:0] wd_q[$];
    logic [AW-1:0] exp_addr[$];
    int            exp_start[$];
    int            exp_size[$];

    int cyc = 0;
    int done_cnt = 0, err_cnt = 0, done_cyc = 0, err_cyc = 0;
    bit req_seen = 0;
    int req_stall = 0, data_dly = 0, stall_cnt = 0, dly_cnt = 0, addr_bad = 0;
    bit pend = 0, inject = 0;
    logic [AW-1:0] held_addr = '0;
    int tests_run = 0, tests_failed = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [WW-1:0] rand_word();
        logic [WW-1:0] w;
        for (int i = 0; i < WW / 32; i++) w[i*32 +: 32] = $urandom;
        return w;
    endfunction

    // Monitor then parameter-buffer responder, all on the falling edge.
    initial begin
        rd_req_ready  = 1'b0;
        rd_data_valid = 1'b0;
        rd_data       = '0;
        forever begin
            @(negedge clk);
            if (scale_set) wr_q.push_back('{scale_reg_start, scale_reg_size, scale_word, mode});
            if (load_done) begin done_cnt++; done_cyc = cyc; end
            if (cfg_err) begin err_cnt++; err_cyc = cyc; end
            if (rd_req_valid) req_seen = 1'b1;
            rd_req_ready  = 1'b0;
            rd_data_valid = 1'b0;
            if (rst) begin
                pend = 1'b0; stall_cnt = 0; dly_cnt = 0;
            end else if (inject) begin
                inject = 1'b0;
                rd_data = rand_word();
                rd_data_valid = 1'b1;
            end else if (rd_req_valid && !pend) begin
                if (stall_cnt == 0) held_addr = rd_req_addr;
                else if (rd_req_addr !== held_addr) addr_bad++;
                if (stall_cnt >= req_stall) begin
                    rd_req_ready = 1'b1;
                    rq_q.push_back(rd_req_addr);
                    pend = 1'b1; stall_cnt = 0; dly_cnt = 0;
                end else begin
                    stall_cnt++;
                end
            end else if (pend && rd_data_ready) begin
                if (dly_cnt >= data_dly) begin
                    rd_data = rand_word();
                    rd_data_valid = 1'b1;
                    wd_q.push_back(rd_data);
                    pend = 1'b0;
                end else begin
                    dly_cnt++;
                end
            end
        end
    end

    // Reference model: what a load command should produce, from the command rules alone.
    function automatic void model_load(input logic [3:0] m, input logic [AW-1:0] base, input int num,
                                       input int s, input int d, output bit legal, output int lat);
        int words, rem;
        logic [AW-1:0] a;
        exp_addr.delete(); exp_start.delete(); exp_size.delete();
        legal = (m <= 4'd1) && (num >= 1) && (num <= 64);
        words = !legal ? 0 : (m == 4'd1) ? (num + 31) / 32 : 1;
        for (int w = 0; w < words; w++) begin
            a = base + AW'(w * 64);
            rem = num - 32 * w;
            exp_addr.push_back(a);
            exp_start.push_back(1 + 32 * w);
            exp_size.push_back((m == 4'd0) ? num : (rem > 32 ? 32 : rem));
        end
        lat = legal ? 2 + words * (3 + s + d) + (words - 1) : 1;
    endfunction

    task automatic run_load(input logic [3:0] m, input logic [AW-1:0] base, input logic [7:0] num,
                            input int s, input int d, output int c0, output logic busy_after);
        int n, done0, err0;
        @(posedge clk);
        wr_q.delete(); rq_q.delete(); wd_q.delete();
        req_seen = 1'b0; addr_bad = 0; req_stall = s; data_dly = d;
        done0 = done_cnt; err0 = err_cnt;
        @(negedge clk);
        load_mode = m; load_base_addr = base; load_channel_num = num; load_start = 1'b1;
        c0 = cyc;
        @(negedge clk);
        load_start = 1'b0;
        n = 0;
        while (done_cnt == done0 && err_cnt == err0 && n < 400) begin
            @(posedge clk);
            n++;
        end
        if (n >= 400) begin
            tests_run++; tests_failed++;
            $display("FAIL load_timeout: no done/err after %0d cycles, required one within 400 (mode %0d num %0d)", n, m, num);
        end
        @(negedge clk);
        busy_after = load_busy;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        tests_run++;
        if ({load_busy, load_done, cfg_err, rd_req_valid, rd_data_ready, scale_set} !== 6'b0) begin
            tests_failed++;
            $display("FAIL reset_ctrl: got %b required 000000", {load_busy, load_done, cfg_err, rd_req_valid, rd_data_ready, scale_set});
        end
        tests_run++;
        if ({mode, scale_reg_start, scale_reg_size, rd_req_addr} !== 52'b0) begin
            tests_failed++;
            $display("FAIL reset_regs: mode %0d start %0d size %0d addr %h, required all 0", mode, scale_reg_start, scale_reg_size, rd_req_addr);
        end
        tests_run++;
        if (scale_word !== '0) begin
            tests_failed++;
            $display("FAIL reset_word: got %h required 0", scale_word);
        end
        @(posedge clk); #2 rst = 1'b0;
        repeat (2) @(negedge clk);
        tests_run++;
        if (load_busy !== 1'b0 || rd_req_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL post_reset_idle: busy %b req %b required 0 0", load_busy, rd_req_valid);
        end
    endtask

    task automatic test_mode0();
        int c0, d0;
        logic b;
        d0 = done_cnt;
        run_load(4'd0, 32'h1000, 8'd64, 0, 0, c0, b);
        tests_run++;
        if (rq_q.size() != 1 || rq_q[0] !== 32'h1000) begin
            tests_failed++;
            $display("FAIL m0_request: %0d requests, first %h; required 1 at 00001000", rq_q.size(), rq_q.size() ? rq_q[0] : 32'hx);
        end
        tests_run++;
        if (wr_q.size() != 1) begin
            tests_failed++;
            $display("FAIL m0_write_count: got %0d required 1", wr_q.size());
        end else begin
            tests_run++;
            if (wr_q[0].start !== 8'd1 || wr_q[0].size !== 8'd64 || wr_q[0].md !== 4'd0) begin
                tests_failed++;
                $display("FAIL m0_write_fields: start %0d size %0d mode %0d required 1 64 0", wr_q[0].start, wr_q[0].size, wr_q[0].md);
            end
            tests_run++;
            if (wd_q.size() != 1 || wr_q[0].word !== wd_q[0]) begin
                tests_failed++;
                $display("FAIL m0_word: got %h required the word the buffer returned", wr_q[0].word);
            end
        end
        tests_run++;
        if (done_cnt - d0 != 1 || done_cyc - c0 != 5) begin
            tests_failed++;
            $display("FAIL m0_done: %0d pulses at latency %0d required 1 at 5", done_cnt - d0, done_cyc - c0);
        end
        tests_run++;
        if (b !== 1'b0) begin
            tests_failed++;
            $display("FAIL m0_busy_drop: busy %b after done required 0", b);
        end
    endtask

    task automatic test_mode1_two_words();
        int c0, d0;
        logic b;
        d0 = done_cnt;
        run_load(4'd1, 32'h2000, 8'd48, 0, 0, c0, b);
        tests_run++;
        if (rq_q.size() != 2 || rq_q[0] !== 32'h2000 || rq_q[1] !== 32'h2040) begin
            tests_failed++;
            $display("FAIL m1_requests: %0d requests, required 2 at 00002000 00002040", rq_q.size());
        end
        tests_run++;
        if (wr_q.size() != 2 || wd_q.size() != 2) begin
            tests_failed++;
            $display("FAIL m1_write_count: got %0d writes, %0d words, required 2 2", wr_q.size(), wd_q.size());
        end else begin
            tests_run++;
            if (wr_q[0].start !== 8'd1 || wr_q[0].size !== 8'd32 || wr_q[1].start !== 8'd33 || wr_q[1].size !== 8'd16) begin
                tests_failed++;
                $display("FAIL m1_write_fields: (%0d,%0d) (%0d,%0d) required (1,32) (33,16)", wr_q[0].start, wr_q[0].size, wr_q[1].start, wr_q[1].size);
            end
            tests_run++;
            if (wr_q[0].word !== wd_q[0] || wr_q[1].word !== wd_q[1] || wr_q[1].md !== 4'd1) begin
                tests_failed++;
                $display("FAIL m1_words: words or mode %0d differ from buffer data / mode 1", wr_q[1].md);
            end
        end
        tests_run++;
        if (done_cnt - d0 != 1 || done_cyc - c0 != 9) begin
            tests_failed++;
            $display("FAIL m1_done: %0d pulses at latency %0d required 1 at 9", done_cnt - d0, done_cyc - c0);
        end
    endtask

    task automatic test_stall();
        int c0;
        logic b;
        run_load(4'd1, 32'h0000_3000, 8'd20, 3, 4, c0, b);
        tests_run++;
        if (addr_bad != 0 || rq_q.size() != 1 || rq_q[0] !== 32'h3000) begin
            tests_failed++;
            $display("FAIL stall_request: %0d address changes, %0d requests; required 0 and 1 at 00003000", addr_bad, rq_q.size());
        end
        tests_run++;
        if (wr_q.size() != 1 || wr_q[0].start !== 8'd1 || wr_q[0].size !== 8'd20 || wr_q[0].word !== wd_q[0]) begin
            tests_failed++;
            $display("FAIL stall_write: %0d writes, required one write start 1 size 20", wr_q.size());
        end
        tests_run++;
        if (done_cyc - c0 != 12) begin
            tests_failed++;
            $display("FAIL stall_latency: got %0d required 12", done_cyc - c0);
        end
    endtask

    task automatic test_illegal();
        logic [3:0] ms[3] = '{4'd2, 4'd0, 4'd1};
        logic [7:0] ns[3] = '{8'd10, 8'd0, 8'd65};
        int c0, e0, d0;
        logic b;
        for (int i = 0; i < 3; i++) begin
            e0 = err_cnt; d0 = done_cnt;
            run_load(ms[i], 32'h8000, ns[i], 0, 0, c0, b);
            tests_run++;
            if (err_cnt - e0 != 1 || err_cyc - c0 != 1 || done_cnt != d0) begin
                tests_failed++;
                $display("FAIL illegal_err[%0d]: %0d err at latency %0d, %0d done; required 1 at 1, 0 done", i, err_cnt - e0, err_cyc - c0, done_cnt - d0);
            end
            tests_run++;
            if (req_seen || wr_q.size() != 0 || b !== 1'b0) begin
                tests_failed++;
                $display("FAIL illegal_quiet[%0d]: req %b writes %0d busy %b required 0 0 0", i, req_seen, wr_q.size(), b);
            end
        end
    endtask

    task automatic test_ignored();
        int c0, d0;
        logic [WW-1:0] sw;
        @(posedge clk);
        wr_q.delete(); rq_q.delete(); wd_q.delete();
        req_stall = 0; data_dly = 0; d0 = done_cnt;
        @(negedge clk);
        load_mode = 4'd0; load_base_addr = 32'h4000; load_channel_num = 8'd10; load_start = 1'b1;
        c0 = cyc;
        @(negedge clk); load_start = 1'b0;
        @(negedge clk); load_mode = 4'd1; load_base_addr = 32'h5000; load_channel_num = 8'd48; load_start = 1'b1;
        @(negedge clk); load_start = 1'b0;
        @(negedge clk);
        @(negedge clk); load_start = 1'b1;
        @(negedge clk); load_start = 1'b0;
        tests_run++;
        if (load_busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL ignore_busy: busy %b the cycle after done, required 0", load_busy);
        end
        repeat (4) @(posedge clk);
        tests_run++;
        if (done_cnt - d0 != 1 || done_cyc - c0 != 5 || rq_q.size() != 1 || load_busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL ignore_start: %0d done at %0d, %0d requests, busy %b; required 1 at 5, 1, 0", done_cnt - d0, done_cyc - c0, rq_q.size(), load_busy);
        end
        tests_run++;
        if (wr_q.size() != 1 || wr_q[0].size !== 8'd10 || mode !== 4'd0 || rq_q[0] !== 32'h4000) begin
            tests_failed++;
            $display("FAIL ignore_trace: %0d writes, mode %0d; required 1 write size 10 at 00004000, mode 0", wr_q.size(), mode);
        end
        sw = scale_word;
        inject = 1'b1;
        repeat (3) @(posedge clk);
        tests_run++;
        if (wr_q.size() != 1 || scale_word !== sw || load_busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL ignore_idle_data: writes %0d busy %b word changed %b; required 1 0 0", wr_q.size(), load_busy, scale_word !== sw);
        end
    endtask

    task automatic test_reset_mid_load();
        int n, d0, c0;
        logic b;
        @(posedge clk);
        wr_q.delete(); rq_q.delete(); wd_q.delete();
        req_stall = 0; data_dly = 6; d0 = done_cnt;
        @(negedge clk);
        load_mode = 4'd1; load_base_addr = 32'h6000; load_channel_num = 8'd48; load_start = 1'b1;
        @(negedge clk); load_start = 1'b0;
        n = 0;
        while (!rd_data_ready && n < 50) begin @(negedge clk); n++; end
        tests_run++;
        if (rd_data_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL rst_reach_wait: data_ready %b after %0d cycles, required 1", rd_data_ready, n);
        end
        @(posedge clk); #2 rst = 1'b1; #1;
        tests_run++;
        if ({load_busy, load_done, cfg_err, rd_req_valid, rd_data_ready, scale_set} !== 6'b0
            || {mode, scale_reg_start, scale_reg_size, rd_req_addr} !== 52'b0 || scale_word !== '0) begin
            tests_failed++;
            $display("FAIL rst_mid_outputs: ctrl %b mode %0d addr %h, required all 0", {load_busy, load_done, cfg_err, rd_req_valid, rd_data_ready, scale_set}, mode, rd_req_addr);
        end
        @(posedge clk); #2 rst = 1'b0;
        @(posedge clk); inject = 1'b1;
        repeat (4) @(posedge clk);
        tests_run++;
        if (wr_q.size() != 0 || done_cnt != d0 || load_busy !== 1'b0 || scale_word !== '0) begin
            tests_failed++;
            $display("FAIL rst_late_data: writes %0d done %0d busy %b; required 0 0 0 and word 0", wr_q.size(), done_cnt - d0, load_busy);
        end
        run_load(4'd1, 32'h7000, 8'd40, 0, 0, c0, b);
        tests_run++;
        if (rq_q.size() != 2 || rq_q[0] !== 32'h7000 || rq_q[1] !== 32'h7040 || done_cyc - c0 != 9) begin
            tests_failed++;
            $display("FAIL rst_fresh_load: %0d requests, latency %0d; required 2 at 00007000/00007040, 9", rq_q.size(), done_cyc - c0);
        end
        tests_run++;
        if (wr_q.size() != 2 || wr_q[1].start !== 8'd33 || wr_q[1].size !== 8'd8 || wr_q[1].word !== wd_q[1]) begin
            tests_failed++;
            $display("FAIL rst_fresh_writes: %0d writes, required 2 ending (33,8)", wr_q.size());
        end
    endtask

    task automatic test_addr_wrap();
        int c0;
        logic b;
        run_load(4'd1, 32'hFFFF_FFC0, 8'd64, 0, 0, c0, b);
        tests_run++;
        if (rq_q.size() != 2 || rq_q[0] !== 32'hFFFF_FFC0 || rq_q[1] !== 32'h0000_0000) begin
            tests_failed++;
            $display("FAIL wrap_addr: %0d requests, second %h; required 2, second 00000000", rq_q.size(), rq_q.size() > 1 ? rq_q[1] : 32'hx);
        end
        tests_run++;
        if (wr_q.size() != 2 || wr_q[1].start !== 8'd33 || wr_q[1].size !== 8'd32) begin
            tests_failed++;
            $display("FAIL wrap_writes: %0d writes, required 2 ending (33,32)", wr_q.size());
        end
    endtask

    task automatic test_random();
        int c0, d0, e0, lat, num, s, d;
        logic [3:0] m;
        logic [AW-1:0] base;
        logic b;
        bit legal, ok;
        for (int it = 0; it < 24; it++) begin
            m    = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(2, 15)) : 4'($urandom_range(0, 1));
            num  = $urandom_range(0, 70);
            base = $urandom;
            s    = $urandom_range(0, 3);
            d    = $urandom_range(0, 3);
            model_load(m, base, num, s, d, legal, lat);
            d0 = done_cnt; e0 = err_cnt;
            run_load(m, base, 8'(num), s, d, c0, b);
            tests_run++;
            if (done_cnt - d0 != int'(legal) || err_cnt - e0 != int'(!legal)
                || (legal ? done_cyc : err_cyc) - c0 != lat || b !== 1'b0) begin
                tests_failed++;
                $display("FAIL rand_status[%0d]: done %0d err %0d latency %0d busy %b; required done %0d latency %0d busy 0 (mode %0d num %0d s %0d d %0d)",
                         it, done_cnt - d0, err_cnt - e0, (legal ? done_cyc : err_cyc) - c0, b, legal, lat, m, num, s, d);
            end
            ok = (rq_q.size() == exp_addr.size()) && (wr_q.size() == exp_addr.size()) && (wd_q.size() == exp_addr.size());
            for (int w = 0; ok && w < exp_addr.size(); w++) begin
                ok = (rq_q[w] === exp_addr[w]) && (wr_q[w].start === 8'(exp_start[w]))
                     && (wr_q[w].size === 8'(exp_size[w])) && (wr_q[w].word === wd_q[w]) && (wr_q[w].md === m);
            end
            tests_run++;
            if (!ok) begin
                tests_failed++;
                $display("FAIL rand_trace[%0d]: %0d requests %0d writes, required %0d of each matching the model (mode %0d num %0d base %h)",
                         it, rq_q.size(), wr_q.size(), exp_addr.size(), m, num, base);
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        load_start = 1'b0;
        load_mode = '0;
        load_base_addr = '0;
        load_channel_num = '0;
        test_reset();
        test_mode0();
        test_mode1_two_words();
        test_stall();
        test_illegal();
        test_ignored();
        test_reset_mid_load();
        test_addr_wrap();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
